// File: rtl/core_pkg.sv
// Shared core definitions: opcode map, NOP encoding, fetch FSM states and the
// IF/ID pipeline register record.
package core_pkg;

  localparam int XLEN = 32;

  // Major opcodes seen by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_U_TYPE = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_HALT   = 7'b1110101;

  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DISCARD,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: request/address out, data/valid back.
interface fetch_stage_if #(
  parameter int PC_W  = 32,
  parameter int INS_W = 32
);
  logic             IMemReq;
  logic [PC_W-1:0]  IMemAddr;
  logic [INS_W-1:0] IMemRdata;
  logic             IMemValid;

  modport master (output IMemReq, IMemAddr, input IMemRdata, IMemValid);
  modport slave  (input IMemReq, IMemAddr, output IMemRdata, IMemValid);
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush to NOP beats load; no load means hold.
module if_id_reg
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   flush,
  input  logic   load,
  input  if_id_t d,
  output if_id_t q
);

  // Register update: reset/flush leave a NOP bubble, PC survives a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (flush) begin
      q <= '{pc: q.pc, instr: NOP_INSTR, valid: 1'b0};
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, fetch FSM, one-entry skid buffer and the IF/ID register.
module fetch_stage #(
  parameter int               PC_W     = 32,
  parameter int               INS_W    = 32,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [INS_W-1:0] NOP      = 32'h00000013
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [PC_W-1:0]  Target,
  input  logic             HaltIn,
  fetch_stage_if.master    imem,
  output logic [PC_W-1:0]  IfIdPC,
  output logic [INS_W-1:0] IfIdInstr,
  output logic             IfIdValid,
  output logic [6:0]       Opcode,
  output logic             Halted
);
  import core_pkg::*;

  fetch_state_t     state_reg, state_next;
  logic [PC_W-1:0]  pc_reg, pc_next;
  logic [PC_W-1:0]  skid_pc_reg, skid_pc_next;
  logic [INS_W-1:0] skid_instr_reg, skid_instr_next;
  logic [PC_W-1:0]  target_reg, target_next;
  logic             halt_flag_reg, halt_flag_next;
  logic             halted_reg, halted_next;

  if_id_t ifid_q, ifid_d;
  logic   ifid_load, ifid_flush;
  logic   req, complete, stall_eff, halt_trig;

  // Request is held through DISCARD so the address stays stable until the
  // outstanding transfer drains; nothing is requested while reset is held.
  assign req       = ((state_reg == FETCH) || (state_reg == DISCARD)) && !reset;
  assign complete  = req && imem.IMemValid;
  // A stall over an empty IF/ID cannot block the incoming word
  assign stall_eff = Stall && ifid_q.valid;
  assign halt_trig = HaltIn && ifid_q.valid && !Stall && !Redirect;

  assign imem.IMemReq  = req;
  assign imem.IMemAddr = pc_reg;

  // State, PC, skid buffer and saved-redirect registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      skid_pc_reg    <= '0;
      skid_instr_reg <= '0;
      target_reg     <= '0;
      halt_flag_reg  <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      skid_pc_reg    <= skid_pc_next;
      skid_instr_reg <= skid_instr_next;
      target_reg     <= target_next;
      halt_flag_reg  <= halt_flag_next;
      halted_reg     <= halted_next;
    end
  end

  // Next state: redirect > drain > halt > normal fetch / skid release.
  // The skid buffer is only meaningful in HOLD, so leaving HOLD empties it.
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    skid_pc_next    = skid_pc_reg;
    skid_instr_next = skid_instr_reg;
    target_next     = target_reg;
    halt_flag_next  = halt_flag_reg;
    halted_next     = halted_reg;
    ifid_load       = 1'b0;
    ifid_flush      = 1'b0;
    ifid_d          = ifid_q;

    if (state_reg != HALTED) begin
      if (Redirect) begin
        ifid_flush = 1'b1;
        if ((state_reg == DISCARD) && halt_flag_reg) begin
          // Already draining towards HALTED; a late redirect cannot revive fetch
          target_next = Target;
          if (complete) state_next = HALTED;
        end else if (!req || complete) begin
          pc_next    = Target;
          state_next = FETCH;
        end else begin
          target_next = Target;
          state_next  = DISCARD;
        end
      end else if (state_reg == DISCARD) begin
        if (complete) begin
          if (halt_flag_reg) begin
            state_next = HALTED;
          end else begin
            pc_next    = target_reg;
            state_next = FETCH;
          end
        end
      end else if (halt_trig) begin
        ifid_load   = 1'b1;
        ifid_d.valid = 1'b0;
        halted_next = 1'b1;
        if ((state_reg == FETCH) && !complete) begin
          halt_flag_next = 1'b1;
          state_next     = DISCARD;
        end else begin
          state_next = HALTED;
        end
      end else if (state_reg == FETCH) begin
        if (complete) begin
          pc_next = pc_reg + PC_W'(4);
          if (stall_eff) begin
            skid_pc_next    = pc_reg;
            skid_instr_next = imem.IMemRdata;
            state_next      = HOLD;
          end else begin
            ifid_load = 1'b1;
            ifid_d    = '{pc: pc_reg, instr: imem.IMemRdata, valid: 1'b1};
          end
        end
      end else if (!Stall) begin
        ifid_load  = 1'b1;
        ifid_d     = '{pc: skid_pc_reg, instr: skid_instr_reg, valid: 1'b1};
        state_next = FETCH;
      end
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .flush (ifid_flush),
    .load  (ifid_load),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign IfIdPC    = ifid_q.pc;
  assign IfIdInstr = ifid_q.instr;
  assign IfIdValid = ifid_q.valid;
  assign Opcode    = ifid_q.instr[6:0];
  assign Halted    = halted_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency instruction memory.
module tb_fetch_stage;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        Stall    = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Target   = 32'h0;
  logic        HaltIn;
  logic [31:0] IfIdPC;
  logic [31:0] IfIdInstr;
  logic        IfIdValid;
  logic [6:0]  Opcode;
  logic        Halted;

  int checks   = 0;
  int failures = 0;

  // Memory model controls
  int lat      = 0;
  bit halt_en  = 1'b0;
  int wait_cnt = 0;

  fetch_stage_if #(.PC_W(32), .INS_W(32)) imem ();

  fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .Stall     (Stall),
    .Redirect  (Redirect),
    .Target    (Target),
    .HaltIn    (HaltIn),
    .imem      (imem),
    .IfIdPC    (IfIdPC),
    .IfIdInstr (IfIdInstr),
    .IfIdValid (IfIdValid),
    .Opcode    (Opcode),
    .Halted    (Halted)
  );

  always #5 clk = ~clk;

  // Memory: word at a = a|0x13 (HALT at 0xC when enabled), valid after lat cycles
  always_comb begin
    imem.IMemValid = imem.IMemReq && (wait_cnt >= lat);
    imem.IMemRdata = (halt_en && imem.IMemAddr == 32'hC) ? 32'h00000075
                                                         : (imem.IMemAddr | 32'h13);
  end

  always @(posedge clk) begin
    if (imem.IMemReq && !imem.IMemValid) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  // Controller stand-in: decodes HALT from the IF/ID opcode
  assign HaltIn = halt_en && (Opcode == 7'b1110101);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; Stall = 1'b0; Redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(negedge clk); #1;
    check("rst_valid",  32'(IfIdValid), 32'd0);
    check("rst_instr",  IfIdInstr, 32'h13);
    check("rst_pc",     IfIdPC, 32'h0);
    check("rst_opcode", 32'(Opcode), 32'h13);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_req",    32'(imem.IMemReq), 32'd0);

    // Zero-wait streaming
    lat = 0;
    reset = 1'b0; #1;
    check("zw_req0",  32'(imem.IMemReq), 32'd1);
    check("zw_addr0", imem.IMemAddr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("zw_addr",  imem.IMemAddr, 32'(4 * (k + 1)));
      check("zw_pc",    IfIdPC, 32'(4 * k));
      check("zw_instr", IfIdInstr, 32'(4 * k) | 32'h13);
      check("zw_valid", 32'(IfIdValid), 32'd1);
    end

    // Latency 3, stall pushes the PC 8 word into the skid buffer
    lat = 3;
    do_reset();
    for (int i = 0; i < 60 && !(IfIdValid && IfIdPC == 32'h4); i++) step();
    check("st_pc4_loaded", IfIdPC, 32'h4);
    Stall = 1'b1;
    repeat (4) step();
    check("st_hold_req",   32'(imem.IMemReq), 32'd0);
    check("st_hold_pc",    IfIdPC, 32'h4);
    check("st_hold_instr", IfIdInstr, 32'h17);
    Stall = 1'b0;
    step();
    check("st_rel_pc",    IfIdPC, 32'h8);
    check("st_rel_instr", IfIdInstr, 32'h1B);
    check("st_rel_valid", 32'(IfIdValid), 32'd1);
    check("st_rel_req",   32'(imem.IMemReq), 32'd1);
    check("st_rel_addr",  imem.IMemAddr, 32'hC);

    // Redirect while the 0x10 fetch is outstanding (latency 2)
    lat = 2;
    do_reset();
    for (int i = 0; i < 60 && !(imem.IMemReq && imem.IMemAddr == 32'h10); i++) step();
    check("rd_wait_addr", imem.IMemAddr, 32'h10);
    Redirect = 1'b1; Target = 32'h100;
    step();
    Redirect = 1'b0;
    check("rd_flush_valid", 32'(IfIdValid), 32'd0);
    check("rd_flush_instr", IfIdInstr, 32'h13);
    check("rd_disc_req",    32'(imem.IMemReq), 32'd1);
    check("rd_disc_addr1",  imem.IMemAddr, 32'h10);
    step();
    check("rd_disc_addr2",  imem.IMemAddr, 32'h10);
    step();
    check("rd_new_addr",    imem.IMemAddr, 32'h100);
    check("rd_drop_valid",  32'(IfIdValid), 32'd0);
    repeat (3) step();
    check("rd_tgt_pc",    IfIdPC, 32'h100);
    check("rd_tgt_valid", 32'(IfIdValid), 32'd1);
    check("rd_tgt_instr", IfIdInstr, 32'h113);

    // Redirect and Stall together over a valid IF/ID
    Redirect = 1'b1; Stall = 1'b1; Target = 32'h200;
    step();
    Redirect = 1'b0; Stall = 1'b0;
    check("rs_valid",  32'(IfIdValid), 32'd0);
    check("rs_instr",  IfIdInstr, 32'h13);
    check("rs_opcode", 32'(Opcode), 32'h13);
    check("rs_pc",     IfIdPC, 32'h100);
    repeat (2) step();
    check("rs_addr", imem.IMemAddr, 32'h200);
    check("rs_req",  32'(imem.IMemReq), 32'd1);

    // Reset in the middle of the 0x20 request
    lat = 3;
    do_reset();
    for (int i = 0; i < 80 && !(imem.IMemReq && imem.IMemAddr == 32'h20); i++) step();
    step();
    check("mr_pending_addr", imem.IMemAddr, 32'h20);
    reset = 1'b1; #1;
    check("mr_valid",  32'(IfIdValid), 32'd0);
    check("mr_instr",  IfIdInstr, 32'h13);
    check("mr_pc",     IfIdPC, 32'h0);
    check("mr_req",    32'(imem.IMemReq), 32'd0);
    check("mr_addr",   imem.IMemAddr, 32'h0);
    check("mr_halted", 32'(Halted), 32'd0);
    @(negedge clk);
    reset = 1'b0; #1;
    check("mr_rel_addr", imem.IMemAddr, 32'h0);
    check("mr_rel_req",  32'(imem.IMemReq), 32'd1);

    // HALT at 0xC with the 0x10 fetch outstanding
    lat = 2; halt_en = 1'b1;
    do_reset();
    for (int i = 0; i < 60 && !(IfIdValid && IfIdPC == 32'hC); i++) step();
    check("hl_instr", IfIdInstr, 32'h75);
    step();
    check("hl_halted",     32'(Halted), 32'd1);
    check("hl_valid",      32'(IfIdValid), 32'd0);
    check("hl_drain_req",  32'(imem.IMemReq), 32'd1);
    check("hl_drain_addr", imem.IMemAddr, 32'h10);
    repeat (2) step();
    for (int k = 0; k < 20; k++) begin
      check("hl_idle_req",   32'(imem.IMemReq), 32'd0);
      check("hl_idle_valid", 32'(IfIdValid), 32'd0);
      check("hl_idle_halt",  32'(Halted), 32'd1);
      step();
    end

    // Reset is the only way out of HALTED
    halt_en = 1'b0;
    do_reset();
    check("hx_halted", 32'(Halted), 32'd0);
    check("hx_addr",   imem.IMemAddr, 32'h0);
    check("hx_req",    32'(imem.IMemReq), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the RISC-V core.
- Owns the PC and fetches over a valid-handshake instruction-memory port.
- Presents the fetched word, and its opcode field, to the decode stage, which holds the controller.
- Handles stall, redirect from branch/JAL/JALR resolution, and the sticky HALT stop raised by the controller.

Parameters:
- PC_W, 32, PC and instruction-memory address width in bits; byte addressed.
- INS_W, 32, instruction width.
- RESET_PC, 0, PC value after reset.
- NOP, 32'h00000013, IF/ID instruction value after reset or flush (addi x0,x0,0).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- Stall  in  1  hazard unit: hold IF/ID and PC.
- Redirect  in  1  taken branch/JAL/JALR: flush and refetch at Target.
- Target  in  PC_W  redirect address.
- HaltIn  in  1  controller Halt for the instruction in IF/ID.
- IMemReq  out  1  fetch request.
- IMemAddr  out  PC_W  fetch address (= PC).
- IMemRdata  in  INS_W  fetched word; meaningful only when IMemValid=1.
- IMemValid  in  1  response valid. May rise in the same cycle as IMemReq (0 wait) or any later cycle.
- IfIdPC  out  PC_W  PC of IF/ID instruction.
- IfIdInstr  out  INS_W  IF/ID instruction.
- IfIdValid  out  1  IF/ID holds a real instruction.
- Opcode  out  7  IfIdInstr[6:0], feeds the controller.
- Halted  out  1  sticky halt indicator.

Behaviour:
- Reset, asynchronous:
  - PC=RESET_PC; state=FETCH; IfIdPC=0; IfIdInstr=NOP; IfIdValid=0; Halted=0.
  - Skid buffer empty; redirect register cleared.
  - IMemReq rises in the first cycle after reset deasserts.
  - Reset mid-request abandons the in-flight fetch; memory tolerates this.
- Handshake:
  - A transfer completes on any cycle with IMemReq=1 and IMemValid=1.
  - While IMemReq=1, IMemAddr is held stable until the transfer completes.
  - IMemReq=1 only in FETCH and DISCARD.
- States:
  - FETCH: request at PC.
    - On completion with Stall=0: IF/ID<={PC, Rdata, 1}; PC<=PC+4, mod 2^PC_W.
    - On completion with Stall=1 and IfIdValid=1: word into skid buffer; PC<=PC+4; go HOLD.
  - HOLD: IMemReq=0; IF/ID unchanged. When Stall=0: IF/ID<=skid; skid emptied; go FETCH. A new request is issued the next cycle.
  - DISCARD: keep old request until completion; drop the returned word.
    - Then PC<=saved target; go FETCH.
    - If the halt flag is set, go HALTED instead.
  - HALTED: IMemReq=0; Halted=1; IfIdValid=0; only reset exits.
- Stall: IF/ID registers hold; Stall with IfIdValid=0 does not block IF/ID loading.
- Redirect (priority over Stall and over any completing transfer):
  - IF/ID<={IfIdPC, NOP, 0}; skid emptied.
  - No transfer pending, or completing this cycle: PC<=Target; state FETCH.
  - Transfer pending and not completing: save Target; go DISCARD.
  - Redirect while in DISCARD overwrites the saved target.
- Halt:
  - Trigger: HaltIn=1, IfIdValid=1, Stall=0, Redirect=0.
  - Effect: IfIdValid<=0; skid emptied; Halted<=1 in the next cycle.
  - Any pending, non-completing fetch goes to DISCARD with the halt flag set. Otherwise go HALTED.
  - No instruction after HALT ever reaches IfIdValid=1.
  - Redirect and HaltIn in the same cycle: Redirect wins.
- Opcode is combinational from IfIdInstr, so it equals NOP[6:0]=0010011 after reset or flush.

Decomposition:
- Shared package core_pkg:
  - opcode constants (LOAD, STORE, R_TYPE, I_TYPE, U_TYPE, BRANCH, JAL, JALR, HALT=7'b1110101);
  - NOP;
  - fetch state enum {FETCH, HOLD, DISCARD, HALTED};
  - typedef if_id_t {pc, instr, valid}.
- One sub-module, if_id_reg: the IF/ID register with stall-hold, flush-to-NOP and async reset.
- The FSM, PC and skid buffer stay in fetch_stage.

Test Plan:
- Zero-wait memory, word at addr a = a|0x13, no stall: IMemAddr 0,4,8,…; IfIdPC lags by one cycle; IfIdInstr at PC 8 = 0x1B; IfIdValid=1 from cycle 2.
- Memory valid 3 cycles after request, Stall=1 for 4 cycles after the PC 4 word is loaded:
  - PC 8 word lands in the skid buffer; IMemReq=0 during HOLD; IfIdPC holds at 4.
  - After release IfIdPC=8, then the PC 12 fetch starts.
- Redirect to 0x100 while the PC 0x10 fetch waits on 2-cycle latency:
  - IMemAddr holds 0x10 until valid; that word is dropped; IfIdValid=0.
  - Next request is 0x100; IfIdPC=0x100 appears with valid.
- Redirect and Stall together with IfIdValid=1: IF/ID becomes NOP/valid 0 despite Stall; next IMemAddr=Target.
- HALT (0x00000075) at PC 0x0C, HaltIn=1:
  - Next cycle Halted=1, IfIdValid=0.
  - IMemReq stays 0 for 20 cycles once the pending fetch drains.
  - The word at 0x10 never becomes valid.
- Assert reset mid-request at PC 0x20: outputs return to reset values immediately; after release IMemAddr=RESET_PC and Halted=0.
